// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit: byte/half/word accesses onto a word-wide memory,
// with sub-word stores done as read-modify-write and a 16-cycle ack timeout.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    // state | meaning
    // IDLE  | waiting for a request, req_ready high
    // RD    | mem_read held until ack or timeout (loads and sub-word store reads)
    // WR    | mem_write held until ack or timeout
    // RESP  | one-cycle response pulse
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    state_t      state;
    state_t      state_nxt;

    logic        write_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic        err_q;
    logic [3:0]  wait_cnt;

    logic        req_bad;
    logic        last_wait;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_ext;
    logic [31:0] merged;

    assign req_bad = (req_size == SIZE_ILL)
                  || ((req_size == SIZE_HALF) && req_addr[0])
                  || ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));

    assign last_wait = (wait_cnt == 4'hF);

    // Extract and extend the addressed lane(s) of the returned word.
    always_comb begin
        lane_byte = mem_rdata[7:0];
        case (addr_q[1:0])
            2'd0:    lane_byte = mem_rdata[7:0];
            2'd1:    lane_byte = mem_rdata[15:8];
            2'd2:    lane_byte = mem_rdata[23:16];
            default: lane_byte = mem_rdata[31:24];
        endcase
        lane_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            SIZE_BYTE: load_ext = {{24{~unsigned_q & lane_byte[7]}}, lane_byte};
            SIZE_HALF: load_ext = {{16{~unsigned_q & lane_half[15]}}, lane_half};
            default:   load_ext = mem_rdata;
        endcase
    end

    // Store data sits right-aligned in data_q until the read returns the old word.
    always_comb begin
        merged = mem_rdata;
        if (size_q == SIZE_BYTE) begin
            case (addr_q[1:0])
                2'd0:    merged[7:0]   = data_q[7:0];
                2'd1:    merged[15:8]  = data_q[7:0];
                2'd2:    merged[23:16] = data_q[7:0];
                default: merged[31:24] = data_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merged[31:16] = data_q[15:0];
        end else begin
            merged[15:0] = data_q[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_bad) begin
                        state_nxt = RESP;
                    end else if (req_write && (req_size == SIZE_WORD)) begin
                        state_nxt = WR;
                    end else begin
                        state_nxt = RD;
                    end
                end
            end
            RD: begin
                if (mem_ack) begin
                    state_nxt = write_q ? WR : RESP;
                end else if (last_wait) begin
                    state_nxt = RESP;
                end
            end
            WR: begin
                if (mem_ack || last_wait) begin
                    state_nxt = RESP;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            write_q    <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            addr_q     <= 32'h0;
            data_q     <= 32'h0;
            err_q      <= 1'b0;
            wait_cnt   <= 4'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        write_q    <= req_write;
                        size_q     <= req_size;
                        unsigned_q <= req_unsigned;
                        addr_q     <= req_addr;
                        data_q     <= req_wdata;
                        err_q      <= req_bad;
                        wait_cnt   <= 4'h0;
                    end
                end
                RD: begin
                    if (mem_ack) begin
                        data_q   <= write_q ? merged : load_ext;
                        wait_cnt <= 4'h0;
                    end else begin
                        if (last_wait) begin
                            err_q  <= 1'b1;
                            data_q <= 32'h0;
                        end
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                WR: begin
                    if (!mem_ack) begin
                        if (last_wait) begin
                            err_q <= 1'b1;
                        end
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        req_ready  = 1'b0;
        busy       = 1'b1;
        resp_valid = 1'b0;
        resp_rdata = 32'h0;
        resp_err   = 1'b0;
        mem_addr   = 32'h0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_wdata  = 32'h0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            RD: begin
                mem_read = 1'b1;
                mem_addr = {addr_q[31:2], 2'b00};
            end
            WR: begin
                mem_write = 1'b1;
                mem_addr  = {addr_q[31:2], 2'b00};
                mem_wdata = data_q;
            end
            default: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = (write_q || err_q) ? 32'h0 : data_q;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a table of single requests against a memory
// that acks after a per-vector delay, plus reset and busy-time request sequences.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int n_cmp = 0;
    int n_bad = 0;

    mem_access_unit dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .busy        (busy),
        .mem_addr    (mem_addr),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mword;
        int          delay;     // strobe cycles before ack; >=16 means never
        int          exp_lat;   // cycles from acceptance edge to resp_valid
        int          exp_reads;
        int          exp_writes;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic wr, logic [1:0] size, logic uns, logic [31:0] addr,
                                logic [31:0] wdata, logic [31:0] mword, int delay,
                                int lat, int rds, int wrs, logic [31:0] ewd,
                                logic [31:0] erd, logic err);
        vec_t v;
        v.wr = wr; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.mword = mword; v.delay = delay; v.exp_lat = lat; v.exp_reads = rds;
        v.exp_writes = wrs; v.exp_wdata = ewd; v.exp_rdata = erd; v.exp_err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Entered and left at #1 after a rising edge with the unit in IDLE.
    task automatic run_vec(input vec_t v, input bit spam, input string name);
        int lat = 1;
        int reads = 0;
        int writes = 0;
        int bad = 0;
        int k = 0;
        bit prev_rd = 1'b0;
        bit prev_wr = 1'b0;
        bit got = 1'b0;
        logic [31:0] rd = 32'h0;
        logic        er = 1'b0;
        chk({name, " ready"}, {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = v.wr; req_size = v.size; req_unsigned = v.uns;
        req_addr = v.addr; req_wdata = v.wdata; mem_rdata = v.mword; mem_ack = 1'b0;
        @(posedge clk); #1;
        if (spam) begin
            req_write = 1'b0; req_size = 2'b10; req_addr = 32'h0000_0200;
            req_wdata = 32'h5A5A_5A5A;
        end else begin
            req_valid = 1'b0;
        end
        while (lat <= 40) begin
            if (mem_read && mem_write) bad++;
            if (mem_read || mem_write) begin
                if (mem_addr !== {v.addr[31:2], 2'b00}) bad++;
                if (mem_write && (mem_wdata !== v.exp_wdata)) bad++;
                if ((mem_read && prev_rd) || (mem_write && prev_wr)) k++;
                else k = 0;
                if (mem_read) reads++;
                if (mem_write) writes++;
                mem_ack = (k >= v.delay);
            end else begin
                mem_ack = 1'b0;
            end
            prev_rd = mem_read;
            prev_wr = mem_write;
            if (resp_valid) begin
                got = 1'b1;
                rd = resp_rdata;
                er = resp_err;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
        req_valid = 1'b0;
        mem_ack = 1'b0;
        chk({name, " resp seen"}, {31'b0, got}, 32'd1);
        chk({name, " latency"}, lat, v.exp_lat);
        chk({name, " rdata"}, rd, v.exp_rdata);
        chk({name, " err"}, {31'b0, er}, {31'b0, v.exp_err});
        chk({name, " reads"}, reads, v.exp_reads);
        chk({name, " writes"}, writes, v.exp_writes);
        chk({name, " strobe addr/data"}, bad, 32'd0);
        @(posedge clk); #1;
        chk({name, " post ready"}, {31'b0, req_ready}, 32'd1);
        chk({name, " post busy"}, {31'b0, busy}, 32'd0);
        chk({name, " post resp_valid"}, {31'b0, resp_valid}, 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        //           wr  sz     un  addr          wdata         mword         dly lat rd wr exp_wdata     exp_rdata     err
        vecs.push_back(mk(0, 2'b10, 0, 32'h0000_0010, 32'h0,        32'hDEAD_BEEF, 0,  2,  1, 0, 32'h0,        32'hDEAD_BEEF, 0));
        vecs.push_back(mk(0, 2'b00, 0, 32'h0000_0013, 32'h0,        32'h8011_2233, 0,  2,  1, 0, 32'h0,        32'hFFFF_FF80, 0));
        vecs.push_back(mk(0, 2'b00, 1, 32'h0000_0013, 32'h0,        32'h8011_2233, 0,  2,  1, 0, 32'h0,        32'h0000_0080, 0));
        vecs.push_back(mk(1, 2'b00, 0, 32'h0000_0021, 32'h0000_00AB, 32'h1122_3344, 0,  3,  1, 1, 32'h1122_AB44, 32'h0,        0));
        vecs.push_back(mk(0, 2'b01, 0, 32'h0000_0001, 32'h0,        32'h1234_5678, 0,  1,  0, 0, 32'h0,        32'h0,        1));
        vecs.push_back(mk(0, 2'b01, 0, 32'h0000_0002, 32'h0,        32'h8001_1234, 0,  2,  1, 0, 32'h0,        32'hFFFF_8001, 0));
        vecs.push_back(mk(0, 2'b01, 1, 32'h0000_0000, 32'h0,        32'h1234_ABCD, 0,  2,  1, 0, 32'h0,        32'h0000_ABCD, 0));
        vecs.push_back(mk(1, 2'b10, 0, 32'h0000_0040, 32'hCAFE_F00D, 32'h0,        0,  2,  0, 1, 32'hCAFE_F00D, 32'h0,        0));
        vecs.push_back(mk(1, 2'b01, 0, 32'h0000_0056, 32'hFFFF_BEEF, 32'h1122_3344, 0,  3,  1, 1, 32'hBEEF_3344, 32'h0,        0));
        vecs.push_back(mk(0, 2'b11, 0, 32'h0000_0000, 32'h0,        32'h1234_5678, 0,  1,  0, 0, 32'h0,        32'h0,        1));
        vecs.push_back(mk(0, 2'b10, 0, 32'h0000_0006, 32'h0,        32'h1234_5678, 0,  1,  0, 0, 32'h0,        32'h0,        1));
        vecs.push_back(mk(0, 2'b00, 0, 32'h0000_0000, 32'h0,        32'h0000_007F, 0,  2,  1, 0, 32'h0,        32'h0000_007F, 0));
        vecs.push_back(mk(1, 2'b00, 0, 32'h0000_0003, 32'h1234_5699, 32'hAABB_CCDD, 0,  3,  1, 1, 32'h99BB_CCDD, 32'h0,        0));
        vecs.push_back(mk(1, 2'b10, 0, 32'h0000_0042, 32'h1111_2222, 32'h0,        0,  1,  0, 0, 32'h0,        32'h0,        1));
        vecs.push_back(mk(1, 2'b00, 0, 32'h0000_0022, 32'h0000_0055, 32'h1122_3344, 2,  7,  3, 3, 32'h1155_3344, 32'h0,        0));
        vecs.push_back(mk(0, 2'b10, 0, 32'h0000_0030, 32'h0,        32'h0BAD_F00D, 15, 17, 16, 0, 32'h0,        32'h0BAD_F00D, 0));
        vecs.push_back(mk(0, 2'b10, 0, 32'h0000_0030, 32'h0,        32'h0BAD_F00D, 16, 17, 16, 0, 32'h0,        32'h0,        1));
        vecs.push_back(mk(1, 2'b10, 0, 32'h0000_0080, 32'h1234_5678, 32'h0,        99, 17, 0, 16, 32'h1234_5678, 32'h0,        1));
        vecs.push_back(mk(1, 2'b00, 0, 32'h0000_0081, 32'h0000_0077, 32'hFFFF_FFFF, 99, 17, 16, 0, 32'h0,        32'h0,        1));

        // Reset with a request pending: reset must win and outputs stay quiet.
        rst = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h0000_0010; req_wdata = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset req_ready", {31'b0, req_ready}, 32'd1);
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("reset resp_err", {31'b0, resp_err}, 32'd0);
        chk("reset resp_rdata", resp_rdata, 32'd0);
        chk("reset strobes", {30'b0, mem_read, mem_write}, 32'd0);
        chk("reset mem_addr", mem_addr, 32'd0);
        chk("reset mem_wdata", mem_wdata, 32'd0);
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) run_vec(vecs[i], 1'b0, $sformatf("v%0d", i));

        // New requests presented while busy must not be taken.
        run_vec(vecs[14], 1'b1, "busy_req_rmw");
        run_vec(vecs[7], 1'b1, "busy_req_wr");

        // Reset during a read whose ack never comes.
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h0000_0030; mem_ack = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("abort pre read", {31'b0, mem_read}, 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort read", {31'b0, mem_read}, 32'd0);
        chk("abort resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("abort ready", {31'b0, req_ready}, 32'd1);
        rst = 1'b1;
        seen = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (resp_valid || mem_read || mem_write) seen++;
        end
        chk("abort quiet", seen, 32'd0);
        run_vec(vecs[0], 1'b0, "after_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset; synchronous and active-low (sampled on clk rising edge, asserted when 0).
REQ-003 SHALL have port req_valid, input, 1, CPU request present.
REQ-004 SHALL have port req_ready, output, 1, unit can accept a request (high only in IDLE).
REQ-005 SHALL have port req_write, input, 1, 1 = store, 0 = load.
REQ-006 SHALL have port req_size, input, 2, access size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-007 SHALL have port req_unsigned, input, 1, loads: 1 = zero-extend, 0 = sign-extend.
REQ-008 SHALL have port req_addr, input, 32, byte address.
REQ-009 SHALL have port req_wdata, input, 32, store data, right-aligned in bits [7:0]/[15:0]/[31:0].
REQ-010 SHALL have port resp_valid, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata, output, 32, extended load data; 0 for stores and errors.
REQ-012 SHALL have port resp_err, output, 1, qualifies resp_valid: misaligned, illegal size or timeout.
REQ-013 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-014 SHALL have port mem_addr, output, 32, word-aligned address ({req_addr[31:2],2'b00}).
REQ-015 SHALL have port mem_read, output, 1, read strobe, held until mem_ack.
REQ-016 SHALL have port mem_write, output, 1, write strobe, held until mem_ack.
REQ-017 SHALL have port mem_wdata, output, 32, full word to write.
REQ-018 SHALL have port mem_rdata, input, 32, word returned; valid when mem_ack and mem_read.
REQ-019 SHALL have port mem_ack, input, 1, memory completes current strobe this cycle.

Function
REQ-020 SHALL implement FSM states IDLE, RD, WR, RESP; one request in flight, no pipelining.
REQ-021 IDLE: on req_valid, SHALL register all req_* fields and go to RESP with error if misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size=11, else RD for loads and byte/half stores, else WR for word stores.
REQ-022 Byte lanes SHALL be little-endian: lane k = bits [8k+7:8k], lane = addr[1:0] (half: addr[1]).
REQ-023 RD: SHALL assert mem_read; on mem_ack latch mem_rdata; loads go to RESP with extracted, extended data; sub-word stores go to WR with req_wdata merged into the addressed lane(s), other lanes unchanged.
REQ-024 WR: SHALL assert mem_write with mem_wdata stable; on mem_ack go to RESP.
REQ-025 mem_read and mem_write SHALL never be high together; mem_addr stable throughout RD/WR.
REQ-026 A 4-bit wait counter SHALL clear on entry to RD/WR, increment each cycle without mem_ack; if the 16th consecutive cycle has no ack, SHALL drop the strobe next cycle and go to RESP with resp_err=1 (a partial RMW SHALL not write).
REQ-027 RESP: resp_valid=1 for exactly one cycle, then IDLE; req_ready=1 again the following cycle.
REQ-028 Minimum latency: word load acked in first RD cycle -> resp_valid 2 cycles after acceptance; byte store with immediate acks -> 3 cycles.
REQ-029 req_valid outside IDLE SHALL be ignored (not captured).

Reset
REQ-030 While rst=0 at a clk edge, SHALL enter IDLE, clear counter and registers; next cycle req_ready=1, all other outputs 0.
REQ-031 Reset mid-transaction SHALL abort it: strobes low and no resp_valid after the reset edge.

Verification
REQ-032 Word load addr 0x10, mem_rdata=0xDEADBEEF ack immediately -> resp_valid 2 cycles later, resp_rdata=0xDEADBEEF, resp_err=0.
REQ-033 Byte load addr 0x13 signed, mem_rdata=0x80112233 -> resp_rdata=0xFFFFFF80; unsigned -> 0x00000080.
REQ-034 Byte store 0xAB to addr 0x21, memory word 0x11223344 -> one read then mem_write with mem_wdata=0x1122AB44 at mem_addr 0x20.
REQ-035 Half load addr 0x01 -> no mem strobe, resp_valid with resp_err=1 one cycle after acceptance.
REQ-036 Word store with mem_ack held low -> mem_write high 16 cycles, then low, resp_err=1; next request accepted normally.
REQ-037 rst=0 during RD with ack pending -> mem_read low after edge, no resp_valid, req_ready=1 after release.
